// File: rtl/stage_if_prefetch_pkg.sv
// rtl/stage_if_prefetch_pkg.sv - shared defaults and constants for the IF prefetch stage
package stage_if_prefetch_pkg;

  localparam int          DEF_PC_WIDTH     = 32;
  localparam int          DEF_INST_WIDTH   = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam int          PC_INC           = 4;

  // Bits needed to hold any value in 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/stage_if_prefetch_sync_fifo.sv
// rtl/stage_if_prefetch_sync_fifo.sv - prefetch buffer FIFO with flush and occupancy count
module stage_if_prefetch_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = CW'(r_wr_ptr - r_rd_ptr);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign w_wr_en = i_push && (!o_full || i_pop) && !i_flush;
  assign w_rd_en = i_pop && !o_empty && !i_flush;

  // Pointer update; flush empties the buffer and overrides push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty gates visibility.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/stage_if_prefetch.sv
// rtl/stage_if_prefetch.sv - IF stage: credit-based IMEM prefetch, redirect flush (FETCH_MISALIGN_CHK_EN)
module stage_if_prefetch
  import stage_if_prefetch_pkg::*;
#(
  parameter int                  PC_WIDTH        = DEF_PC_WIDTH,
  parameter int                  INST_WIDTH      = DEF_INST_WIDTH,
  parameter int                  FIFO_DEPTH      = 4,
  parameter int                  MAX_OUTSTANDING = 4,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR    = PC_WIDTH'(DEF_RESET_VECTOR)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_redirect_valid,
  input  logic [PC_WIDTH-1:0]   i_redirect_pc,
  output logic                  o_imem_req_valid,
  input  logic                  i_imem_req_ready,
  output logic [PC_WIDTH-1:0]   o_imem_req_addr,
  input  logic                  i_imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] i_imem_rsp_data,
  output logic                  o_inst_valid,
  input  logic                  i_inst_ready,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [PC_WIDTH-1:0]   o_inst_pc,
  output logic [PC_WIDTH-1:0]   o_inst_pc_next,
  output logic                  o_misalign_fault
);

  localparam int OW  = cnt_width(MAX_OUTSTANDING);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PC_WIDTH-1:0] W_PC_INC = PC_WIDTH'(PC_INC);

  logic [PC_WIDTH-1:0] r_fetch_pc;
  logic [PC_WIDTH-1:0] r_head_pc;
  logic [OW-1:0]       r_outstanding;
  logic [OW-1:0]       r_discard;
  logic                r_run;

  logic [OW-1:0]       w_outstanding_next;
  logic [FCW-1:0]      w_fifo_count;
  logic                w_fifo_empty;
  logic                w_fifo_full_unused;
  logic                w_credit_ok;
  logic                w_req_fire;
  logic                w_rsp_drop;
  logic                w_push;
  logic                w_pop;
  logic                w_halt;
  logic [PC_WIDTH-1:0] w_redirect_pc_load;

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_misalign;

  // Sticky fault: any unaligned redirect halts fetching until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_misalign <= 1'b0;
    else if (i_redirect_valid && (i_redirect_pc[1:0] != 2'b00)) r_misalign <= 1'b1;
  end

  assign w_halt             = r_misalign;
  assign o_misalign_fault   = r_misalign;
  assign w_redirect_pc_load = i_redirect_pc;
`else
  logic w_unused_pc_lsb;

  assign w_unused_pc_lsb    = ^i_redirect_pc[1:0];
  assign w_halt             = 1'b0;
  assign o_misalign_fault   = 1'b0;
  assign w_redirect_pc_load = {i_redirect_pc[PC_WIDTH-1:2], 2'b00};
`endif

  // Credits: in-flight plus buffered never exceeds the buffer, so responses always have a slot.
  assign w_credit_ok = ((32'(r_outstanding) + 32'(w_fifo_count)) < 32'(FIFO_DEPTH)) &&
                       (32'(r_outstanding) < 32'(MAX_OUTSTANDING));

  assign o_imem_req_valid = r_run && !i_redirect_valid && !w_halt && w_credit_ok;
  assign o_imem_req_addr  = r_fetch_pc;
  assign w_req_fire       = o_imem_req_valid && i_imem_req_ready;

  assign w_rsp_drop = i_imem_rsp_valid && (r_discard != '0);
  assign w_push     = i_imem_rsp_valid && !w_rsp_drop && !i_redirect_valid;
  assign o_inst_valid = !w_fifo_empty;
  assign w_pop      = o_inst_valid && i_inst_ready && !i_redirect_valid;

  assign o_inst_pc      = r_head_pc;
  assign o_inst_pc_next = r_head_pc + W_PC_INC;

  // A request issued and a response retired in the same cycle cancel out.
  always_comb begin
    w_outstanding_next = r_outstanding;
    case ({w_req_fire, i_imem_rsp_valid})
      2'b10:   w_outstanding_next = r_outstanding + OW'(1);
      2'b01:   w_outstanding_next = r_outstanding - OW'(1);
      default: w_outstanding_next = r_outstanding;
    endcase
  end

  // Fetch is enabled from the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_run <= 1'b0;
    else          r_run <= 1'b1;
  end

  // Fetch and head PCs: redirect reloads both, otherwise advance on issue / pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc <= RESET_VECTOR;
      r_head_pc  <= RESET_VECTOR;
    end else if (i_redirect_valid) begin
      r_fetch_pc <= w_redirect_pc_load;
      r_head_pc  <= w_redirect_pc_load;
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + W_PC_INC;
      if (w_pop)      r_head_pc  <= r_head_pc + W_PC_INC;
    end
  end

  // Every response still in flight after a redirect belongs to the old path and is discarded;
  // no request issues in a redirect cycle, so the post-edge outstanding count is that number.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (i_redirect_valid) r_discard <= w_outstanding_next;
      else if (w_rsp_drop)  r_discard <= r_discard - OW'(1);
    end
  end

  stage_if_prefetch_sync_fifo #(
    .WIDTH (INST_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CW    (FCW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (i_imem_rsp_data),
    .i_pop   (w_pop),
    .i_flush (i_redirect_valid),
    .o_data  (o_inst),
    .o_full  (w_fifo_full_unused),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

endmodule

// File: tb/tb_stage_if_prefetch.sv
// tb/tb_stage_if_prefetch.sv - randomized queue-model bench for stage_if_prefetch
module tb_stage_if_prefetch;

  localparam int DEPTH = 4;
  localparam int MAXO  = 4;

  logic        clk;
  logic        reset_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_next;
  logic        misalign_fault;

  stage_if_prefetch #(
    .PC_WIDTH        (32),
    .INST_WIDTH      (32),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_VECTOR    (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_imem_req_valid (imem_req_valid),
    .i_imem_req_ready (imem_req_ready),
    .o_imem_req_addr  (imem_req_addr),
    .i_imem_rsp_valid (imem_rsp_valid),
    .i_imem_rsp_data  (imem_rsp_data),
    .o_inst_valid     (inst_valid),
    .i_inst_ready     (inst_ready),
    .o_inst           (inst),
    .o_inst_pc        (inst_pc),
    .o_inst_pc_next   (inst_pc_next),
    .o_misalign_fault (misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit stale; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  req_t        inflight[$];
  ent_t        buf_q[$];
  logic [31:0] m_fetch_pc;
  bit          m_fault;
  bit          m_run;
  int          cyc;
  int          last_due;
  int          lat_min;
  int          lat_max;
  int          n_tests;
  int          n_fail;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    inflight.delete();
    buf_q.delete();
    m_fetch_pc = 32'h0;
    m_fault    = 1'b0;
    m_run      = 1'b0;
    last_due   = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"},  32'(imem_req_valid), 32'd0);
    check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_fault"},      32'(misalign_fault), 32'd0);
    check({tag, "_req_addr"},   imem_req_addr, 32'h0);
    check({tag, "_inst_pc"},    inst_pc, 32'h0);
    check({tag, "_pc_next"},    inst_pc_next, 32'h4);
  endtask

  // One clock cycle: drive inputs, check DUT against the queue model, then advance the model.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rq_rdy, input bit in_rdy);
    bit   exp_req;
    bit   exp_iv;
    bit   rsp;
    int   due;
    req_t r;
    ent_t e;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = rq_rdy;
    inst_ready     = in_rdy;
    rsp            = (inflight.size() > 0) && (inflight[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? inst_of(inflight[0].addr) : 32'hDEAD_BEEF;
    exp_req = m_run && !redir && !m_fault &&
              (inflight.size() + buf_q.size() < DEPTH) && (inflight.size() < MAXO);
    exp_iv  = buf_q.size() > 0;
    @(negedge clk);
    check("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) check("req_addr", imem_req_addr, m_fetch_pc);
    check("inst_valid", 32'(inst_valid), 32'(exp_iv));
    if (exp_iv) begin
      check("inst", inst, buf_q[0].data);
      check("inst_pc", inst_pc, buf_q[0].pc);
      check("inst_pc_next", inst_pc_next, buf_q[0].pc + 32'd4);
    end
    check("misalign_fault", 32'(misalign_fault), 32'(m_fault));
    @(posedge clk);
    if (rsp) begin
      r = inflight.pop_front();
      if (!r.stale && !redir) begin
        e.pc   = r.addr;
        e.data = inst_of(r.addr);
        buf_q.push_back(e);
      end
    end
    if (exp_iv && in_rdy && !redir) void'(buf_q.pop_front());
    if (exp_req && rq_rdy) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      r.addr  = m_fetch_pc;
      r.stale = 1'b0;
      r.due   = due;
      inflight.push_back(r);
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (redir) begin
      buf_q.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
      if (rpc[1:0] != 2'b00) m_fault = 1'b1;
      m_fetch_pc = rpc;
`else
      m_fetch_pc = rpc & 32'hFFFF_FFFC;
`endif
    end
    m_run = 1'b1;
    cyc++;
    #1;
  endtask

  initial begin
    logic [31:0] rpc;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    lat_min = 1;
    lat_max = 1;
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    inst_ready     = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    cyc     = 1;

    // 1-cycle IMEM, ID always ready: one instruction per cycle.
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    // ID stalled: credits run out, then drain in order.
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    // Latency 3 with several requests in flight, then redirect to 0x100.
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h100, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    // Redirect coinciding with pop and response, then back-to-back redirects.
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h200, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    lat_min = 2;
    lat_max = 4;
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h300, 1'b1, 1'b1);
    step(1'b1, 32'h400, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    // IMEM not ready for 5 cycles: address holds.
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    // PC wrap past the top of the address space.
    step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        lat_min = 1;
        lat_max = $urandom_range(6, 1);
      end
      rpc = $urandom & 32'h0000_FFFF;
`ifdef FETCH_MISALIGN_CHK_EN
      rpc = rpc & 32'hFFFF_FFFC;
`endif
      step(($urandom_range(19, 0) == 0), rpc, ($urandom_range(3, 0) != 0),
           ($urandom_range(2, 0) != 0));
    end

    // Unaligned redirect: faults and halts with the check, else resumes aligned.
    step(1'b1, 32'h102, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Reset asserted mid-operation, with traffic in flight.
    lat_min = 1;
    lat_max = 3;
    step(1'b1, 32'h500, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) step(1'b0, 32'h0, ($urandom_range(3, 0) != 0),
                                      ($urandom_range(2, 0) != 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
